// File: rtl/pc_fetch_sequencer_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
// Optional trap support in the top is enabled by defining PC_SEQ_TRAP_EN.
package pc_fetch_sequencer_pkg;

   localparam int unsigned PC_XLEN          = 32;
   localparam logic [31:0] RESET_VECTOR_DEF = 32'h0040_0000;
   localparam logic [31:0] TRAP_VECTOR_DEF  = 32'h0040_0004;
   localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;

   typedef enum logic [1:0] {
      FS_IDLE,
      FS_FETCH,
      FS_HOLD
   } fetch_state_t;

endpackage

// File: rtl/pc_fetch_sequencer_if.sv
// Fetch-side bus bundle: imem req/ack, decode valid/ready and execute redirect.
// master = the sequencer, slave = memory/decode/execute environment.
interface pc_fetch_sequencer_if
   import pc_fetch_sequencer_pkg::*;
#(
   parameter int unsigned XLEN = PC_XLEN
);
   logic            o_imem_req;
   logic [XLEN-1:0] o_imem_addr;
   logic            i_imem_ack;
   logic [31:0]     i_imem_rdata;
   logic            o_instr_valid;
   logic [31:0]     o_instr;
   logic [XLEN-1:0] o_instr_pc;
   logic            i_instr_ready;
   logic            i_redirect_valid;
   logic [XLEN-1:0] i_redirect_pc;
   logic            o_misaligned;

   modport master (
      output o_imem_req, o_imem_addr, o_instr_valid, o_instr, o_instr_pc, o_misaligned,
      input  i_imem_ack, i_imem_rdata, i_instr_ready, i_redirect_valid, i_redirect_pc
   );

   modport slave (
      input  o_imem_req, o_imem_addr, o_instr_valid, o_instr, o_instr_pc, o_misaligned,
      output i_imem_ack, i_imem_rdata, i_instr_ready, i_redirect_valid, i_redirect_pc
   );
endinterface

// File: rtl/pc_fetch_sequencer_pc_next_sel.sv
// Next-PC selection: trap > redirect > sequential advance > hold.
// Redirect targets are word-aligned; a non-zero low pair is flagged.
module pc_next_sel #(
   parameter int unsigned     XLEN        = 32,
   parameter logic [XLEN-1:0] TRAP_VECTOR = 32'h0040_0004
) (
   input  logic [XLEN-1:0] pc_i,
   input  logic            trap_i,
   input  logic            redirect_valid_i,
   input  logic [XLEN-1:0] redirect_pc_i,
   input  logic            advance_i,
   output logic [XLEN-1:0] pc_o,
   output logic            take_o,
   output logic            misalign_o
);

   always_comb begin
      pc_o       = pc_i;
      take_o     = 1'b0;
      misalign_o = 1'b0;
      if (trap_i) begin
         pc_o   = TRAP_VECTOR;
         take_o = 1'b1;
      end else if (redirect_valid_i) begin
         pc_o       = {redirect_pc_i[XLEN-1:2], 2'b00};
         take_o     = 1'b1;
         misalign_o = |redirect_pc_i[1:0];
      end else if (advance_i) begin
         pc_o = pc_i + XLEN'(4);
      end
   end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Program counter owner and one-outstanding-request instruction fetch FSM.
// Define PC_SEQ_TRAP_EN to add i_trap / o_mepc.
module pc_fetch_sequencer
   import pc_fetch_sequencer_pkg::*;
#(
   parameter int unsigned     XLEN         = PC_XLEN,
   parameter logic [XLEN-1:0] RESET_VECTOR = RESET_VECTOR_DEF,
   parameter logic [XLEN-1:0] TRAP_VECTOR  = TRAP_VECTOR_DEF
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   pc_fetch_sequencer_if.master   bus
`ifdef PC_SEQ_TRAP_EN
   ,
   input  logic                   i_trap,
   output logic [XLEN-1:0]        o_mepc
`endif
);

   fetch_state_t    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d, addr_q, addr_d, instr_pc_q, instr_pc_d;
   logic [31:0]     instr_q, instr_d;
   logic            valid_q, valid_d, squash_q, squash_d, misal_q, misal_d;
   logic            trap, advance, take, misal_set;
   logic [XLEN-1:0] pc_sel;

`ifdef PC_SEQ_TRAP_EN
   logic [XLEN-1:0] mepc_q, mepc_d;
   assign trap   = i_trap;
   assign o_mepc = mepc_q;
`else
   assign trap = 1'b0;
`endif

   assign advance = (state_q == FS_FETCH) && bus.i_imem_ack && !squash_q;

   pc_next_sel #(
      .XLEN        (XLEN),
      .TRAP_VECTOR (TRAP_VECTOR)
   ) u_next (
      .pc_i             (pc_q),
      .trap_i           (trap),
      .redirect_valid_i (bus.i_redirect_valid),
      .redirect_pc_i    (bus.i_redirect_pc),
      .advance_i        (advance),
      .pc_o             (pc_sel),
      .take_o           (take),
      .misalign_o       (misal_set)
   );

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_sel;
      addr_d     = addr_q;
      instr_d    = instr_q;
      instr_pc_d = instr_pc_q;
      valid_d    = valid_q;
      squash_d   = squash_q;
      misal_d    = misal_q | misal_set;
      unique case (state_q)
         FS_IDLE:  state_d = FS_FETCH;
         FS_FETCH: begin
            if (bus.i_imem_ack) begin
               squash_d = 1'b0;
               if (!take && !squash_q) begin
                  instr_d    = bus.i_imem_rdata;
                  instr_pc_d = pc_q;
                  valid_d    = 1'b1;
                  state_d    = FS_HOLD;
               end
            end else if (take) begin
               squash_d = 1'b1;
            end
         end
         FS_HOLD: begin
            if (take || bus.i_instr_ready) begin
               valid_d = 1'b0;
               state_d = FS_FETCH;
            end
         end
         default:  state_d = FS_IDLE;
      endcase
      // The in-flight address is frozen until its ack; pc may already hold a squash target.
      if (!(state_q == FS_FETCH && !bus.i_imem_ack)) begin
         addr_d = pc_d;
      end
   end

`ifdef PC_SEQ_TRAP_EN
   always_comb begin
      mepc_d = mepc_q;
      if (i_trap) begin
         mepc_d = (state_q == FS_HOLD) ? instr_pc_q : pc_q;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) mepc_q <= RESET_VECTOR;
      else          mepc_q <= mepc_d;
   end
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= FS_IDLE;
         pc_q       <= RESET_VECTOR;
         addr_q     <= RESET_VECTOR;
         instr_q    <= INSTR_NOP;
         instr_pc_q <= RESET_VECTOR;
         valid_q    <= 1'b0;
         squash_q   <= 1'b0;
         misal_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         addr_q     <= addr_d;
         instr_q    <= instr_d;
         instr_pc_q <= instr_pc_d;
         valid_q    <= valid_d;
         squash_q   <= squash_d;
         misal_q    <= misal_d;
      end
   end

   assign bus.o_imem_req    = (state_q == FS_FETCH);
   assign bus.o_imem_addr   = addr_q;
   assign bus.o_instr_valid = valid_q;
   assign bus.o_instr       = instr_q;
   assign bus.o_instr_pc    = instr_pc_q;
   assign bus.o_misaligned  = misal_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed bench for pc_fetch_sequencer; trap vectors included when PC_SEQ_TRAP_EN is defined.
module tb_pc_fetch_sequencer;

   localparam logic [31:0] RV  = 32'h0040_0000;
   localparam logic [31:0] TV  = 32'h0040_0004;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   vectors = 0;
   int   miscompares = 0;

`ifdef PC_SEQ_TRAP_EN
   logic        trap = 1'b0;
   logic [31:0] mepc;
`endif

   pc_fetch_sequencer_if #(.XLEN(32)) bus_if ();

   pc_fetch_sequencer #(
      .XLEN         (32),
      .RESET_VECTOR (RV),
      .TRAP_VECTOR  (TV)
   ) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus_if)
`ifdef PC_SEQ_TRAP_EN
      ,
      .i_trap  (trap),
      .o_mepc  (mepc)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Entered #1 after the edge where the request first becomes visible; ack lands two edges later.
   task automatic do_fetch(input logic [31:0] a, input logic [31:0] d);
      chk1("req_on", bus_if.o_imem_req, 1'b1);
      chk("req_addr", bus_if.o_imem_addr, a);
      chk1("no_valid_in_fetch", bus_if.o_instr_valid, 1'b0);
      tick();
      chk("addr_stable", bus_if.o_imem_addr, a);
      bus_if.i_imem_ack   = 1'b1;
      bus_if.i_imem_rdata = d;
      tick();
      bus_if.i_imem_ack   = 1'b0;
      bus_if.i_imem_rdata = 32'h0;
      chk1("valid_after_ack", bus_if.o_instr_valid, 1'b1);
      chk("instr", bus_if.o_instr, d);
      chk("instr_pc", bus_if.o_instr_pc, a);
      chk1("req_off_hold", bus_if.o_imem_req, 1'b0);
   endtask

   initial begin
      bus_if.i_imem_ack       = 1'b0;
      bus_if.i_imem_rdata     = 32'h0;
      bus_if.i_instr_ready    = 1'b1;
      bus_if.i_redirect_valid = 1'b0;
      bus_if.i_redirect_pc    = 32'h0;

      #2 rst_n = 1'b0;
      tick();
      tick();
      chk1("rst_req", bus_if.o_imem_req, 1'b0);
      chk1("rst_valid", bus_if.o_instr_valid, 1'b0);
      chk("rst_instr", bus_if.o_instr, NOP);
      chk("rst_instr_pc", bus_if.o_instr_pc, RV);
      chk1("rst_misaligned", bus_if.o_misaligned, 1'b0);
`ifdef PC_SEQ_TRAP_EN
      chk("rst_mepc", mepc, RV);
`endif
      rst_n = 1'b1;
      tick();

      // Straight-line fetch, decode always ready.
      do_fetch(32'h0040_0000, 32'hA000_0001);
      tick();
      do_fetch(32'h0040_0004, 32'hA000_0002);
      tick();
      do_fetch(32'h0040_0008, 32'hA000_0003);
      tick();

      // Redirect while the request to 0x40000C is outstanding.
      chk("pending_addr", bus_if.o_imem_addr, 32'h0040_000C);
      bus_if.i_redirect_valid = 1'b1;
      bus_if.i_redirect_pc    = 32'h0040_0100;
      tick();
      bus_if.i_redirect_valid = 1'b0;
      chk("squash_addr_frozen", bus_if.o_imem_addr, 32'h0040_000C);
      chk1("squash_req_held", bus_if.o_imem_req, 1'b1);
      bus_if.i_imem_ack   = 1'b1;
      bus_if.i_imem_rdata = 32'hBAD0_000C;
      tick();
      bus_if.i_imem_ack = 1'b0;
      chk1("squashed_not_valid", bus_if.o_instr_valid, 1'b0);
      do_fetch(32'h0040_0100, 32'hA000_0100);

      // Decode stalls for five cycles.
      bus_if.i_instr_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk1("stall_valid", bus_if.o_instr_valid, 1'b1);
         chk("stall_instr", bus_if.o_instr, 32'hA000_0100);
         chk("stall_instr_pc", bus_if.o_instr_pc, 32'h0040_0100);
         chk1("stall_no_req", bus_if.o_imem_req, 1'b0);
      end
      bus_if.i_instr_ready = 1'b1;
      tick();

      // Redirect coincident with ack: data dropped, next request goes straight to target.
      chk("pre_ack_addr", bus_if.o_imem_addr, 32'h0040_0104);
      tick();
      bus_if.i_imem_ack       = 1'b1;
      bus_if.i_imem_rdata     = 32'hBAD0_0104;
      bus_if.i_redirect_valid = 1'b1;
      bus_if.i_redirect_pc    = 32'h0040_0200;
      tick();
      bus_if.i_imem_ack       = 1'b0;
      bus_if.i_redirect_valid = 1'b0;
      chk1("ack_redirect_no_valid", bus_if.o_instr_valid, 1'b0);
      do_fetch(32'h0040_0200, 32'hA000_0200);
      chk1("misaligned_still_0", bus_if.o_misaligned, 1'b0);

      // Misaligned redirect in HOLD, with ready in the same cycle.
      bus_if.i_redirect_valid = 1'b1;
      bus_if.i_redirect_pc    = 32'h0040_0302;
      tick();
      bus_if.i_redirect_valid = 1'b0;
      chk1("hold_redirect_drop", bus_if.o_instr_valid, 1'b0);
      chk1("misaligned_set", bus_if.o_misaligned, 1'b1);
      do_fetch(32'h0040_0300, 32'hA000_0300);
      chk1("misaligned_sticky", bus_if.o_misaligned, 1'b1);
      tick();

      // Asynchronous reset mid-request, then a late ack while IDLE.
      chk("pre_reset_addr", bus_if.o_imem_addr, 32'h0040_0304);
      rst_n = 1'b0;
      #1;
      chk1("async_rst_req", bus_if.o_imem_req, 1'b0);
      chk1("async_rst_valid", bus_if.o_instr_valid, 1'b0);
      chk1("async_rst_misaligned", bus_if.o_misaligned, 1'b0);
      chk("async_rst_instr", bus_if.o_instr, NOP);
      tick();
      rst_n = 1'b1;
      bus_if.i_imem_ack   = 1'b1;
      bus_if.i_imem_rdata = 32'hBAD0_0304;
      tick();
      bus_if.i_imem_ack = 1'b0;
      chk1("late_ack_ignored", bus_if.o_instr_valid, 1'b0);
      do_fetch(RV, 32'hA000_0400);

      // Sequential advance wraps past the top of the address space.
      bus_if.i_redirect_valid = 1'b1;
      bus_if.i_redirect_pc    = 32'hFFFF_FFFC;
      tick();
      bus_if.i_redirect_valid = 1'b0;
      do_fetch(32'hFFFF_FFFC, 32'hA000_FFFC);
      tick();
      chk("wrap_addr", bus_if.o_imem_addr, 32'h0000_0000);

`ifdef PC_SEQ_TRAP_EN
      // Trap outranks a simultaneous redirect while a request is outstanding.
      trap                    = 1'b1;
      bus_if.i_redirect_valid = 1'b1;
      bus_if.i_redirect_pc    = 32'h0040_0800;
      tick();
      trap                    = 1'b0;
      bus_if.i_redirect_valid = 1'b0;
      chk("trap_mepc", mepc, 32'h0000_0000);
      chk("trap_addr_frozen", bus_if.o_imem_addr, 32'h0000_0000);
      bus_if.i_imem_ack = 1'b1;
      tick();
      bus_if.i_imem_ack = 1'b0;
      chk1("trap_squash_no_valid", bus_if.o_instr_valid, 1'b0);
      chk("trap_addr", bus_if.o_imem_addr, TV);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
